// File: rtl/fifo_rd_framer_if.sv
// Read-side bundle between the async FIFO, the drain framer and its stream consumer.
// The slave side is the framer; the master side is whoever owns the FIFO and the sink.
interface fifo_rd_framer_if #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
);
    logic [DSIZE-1:0] fifo_rd_data;
    logic             fifo_rd_empty;
    logic             fifo_rd_inc;
    logic             en;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic [CNT_W-1:0] pkt_count;
    logic             busy;

    modport slave (
        input  fifo_rd_data, fifo_rd_empty, en, m_ready,
        output fifo_rd_inc, m_data, m_valid, m_last, pkt_count, busy
    );

    modport master (
        output fifo_rd_data, fifo_rd_empty, en, m_ready,
        input  fifo_rd_inc, m_data, m_valid, m_last, pkt_count, busy
    );
endinterface

// File: rtl/fifo_rd_framer.sv
// Drains the async FIFO onto a valid/ready stream, tags every PKT_LEN-th word as last,
// and only stops popping on packet boundaries so no truncated packet is ever emitted.
module fifo_rd_framer #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 4,
    parameter int RD_LAT  = 0,
    parameter int CNT_W   = 16
) (
    input logic             rd_clk,
    input logic             rd_rst,
    fifo_rd_framer_if.slave bus
);
    localparam int D  = 2 + RD_LAT;
    localparam int OW = $clog2(D + 1);
    localparam int IW = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state_q, state_d;
    logic [DSIZE-1:0] buf_q [D];
    logic [DSIZE-1:0] buf_d [D];
    logic [OW-1:0]    occ_q, occ_d;
    logic             infl_q, infl_d;
    logic [IW-1:0]    out_idx_q, out_idx_d;
    logic [IW-1:0]    pop_idx_q, pop_idx_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;

    logic          pop_ok, rd_inc, capture, xfer, valid, last;
    logic [OW:0]   fill;
    logic [OW-1:0] wr_pos;

    // Pop gating looks only at registered state and occupancy, never at m_ready.
    assign pop_ok  = (state_q == RUN) || (state_q == FINISH);
    assign fill    = {1'b0, occ_q} + (OW + 1)'(infl_q);
    assign rd_inc  = pop_ok && !bus.fifo_rd_empty && (fill < (OW + 1)'(D));
    assign capture = (RD_LAT == 0) ? rd_inc : infl_q;
    assign valid   = (occ_q != '0);
    assign last    = valid && (out_idx_q == LAST_IDX);
    assign xfer    = valid && bus.m_ready;
    assign wr_pos  = xfer ? occ_q - 1'b1 : occ_q;

    assign bus.fifo_rd_inc = rd_inc;
    assign bus.m_valid     = valid;
    assign bus.m_data      = buf_q[0];
    assign bus.m_last      = last;
    assign bus.pkt_count   = pkt_q;
    assign bus.busy        = valid || infl_q;

    // Head always lives in slot 0 so m_data is a plain register output.
    always_comb begin
        buf_d = buf_q;
        if (xfer) begin
            for (int i = 0; i < D - 1; i++) buf_d[i] = buf_q[i + 1];
        end
        if (capture) begin
            for (int i = 0; i < D; i++) begin
                if (wr_pos == OW'(i)) buf_d[i] = bus.fifo_rd_data;
            end
        end
        occ_d  = occ_q + OW'(capture) - OW'(xfer);
        infl_d = (RD_LAT != 0) && rd_inc;

        out_idx_d = out_idx_q;
        if (xfer) out_idx_d = (out_idx_q == LAST_IDX) ? '0 : out_idx_q + 1'b1;
        pop_idx_d = pop_idx_q;
        if (rd_inc) pop_idx_d = (pop_idx_q == LAST_IDX) ? '0 : pop_idx_q + 1'b1;
        pkt_d = pkt_q + CNT_W'(xfer && last);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = RUN;
            end
            RUN: begin
                if (!bus.en) begin
                    if (pop_idx_q == '0 && !rd_inc) state_d = IDLE;
                    else                            state_d = FINISH;
                end
            end
            FINISH: begin
                // en is ignored here: the packet in progress must be completed.
                if (rd_inc && pop_idx_q == LAST_IDX) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            for (int i = 0; i < D; i++) buf_q[i] <= '0;
            occ_q     <= '0;
            infl_q    <= 1'b0;
            out_idx_q <= '0;
            pop_idx_q <= '0;
            pkt_q     <= '0;
        end else begin
            for (int i = 0; i < D; i++) buf_q[i] <= buf_d[i];
            occ_q     <= occ_d;
            infl_q    <= infl_d;
            out_idx_q <= out_idx_d;
            pop_idx_q <= pop_idx_d;
            pkt_q     <= pkt_d;
        end
    end
endmodule

// File: tb/tb_fifo_rd_framer.sv
// Two framers (RD_LAT 0 and 1) fed by behavioural FIFOs; a negedge monitor checks every
// transfer against a per-lane expected queue filled when the words are pushed.
module tb_fifo_rd_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] en, m_ready, force_empty;
    logic [7:0] mem [2][64];
    logic [5:0] rp [2] = '{6'd0, 6'd0};
    logic [5:0] wp [2] = '{6'd0, 6'd0};
    logic [7:0] lat_d = 8'h00;

    logic [1:0]  inc, emp, mv, ml, bz;
    logic [7:0]  md [2];
    logic [15:0] pk [2];

    logic [8:0] exp_q [2][$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_pop [2] = '{-1, -1};
    int first_vld [2] = '{-1, -1};
    int first_x   [2] = '{-1, -1};
    int last_x    [2] = '{-1, -1};

    fifo_rd_framer_if #(.DSIZE(8), .CNT_W(16)) if0 ();
    fifo_rd_framer_if #(.DSIZE(8), .CNT_W(16)) if1 ();

    fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4), .RD_LAT(0), .CNT_W(16)) dut0 (
        .rd_clk(clk), .rd_rst(rst), .bus(if0.slave));
    fifo_rd_framer #(.DSIZE(8), .PKT_LEN(4), .RD_LAT(1), .CNT_W(16)) dut1 (
        .rd_clk(clk), .rd_rst(rst), .bus(if1.slave));

    assign emp[0] = (rp[0] == wp[0]) || force_empty[0];
    assign emp[1] = (rp[1] == wp[1]) || force_empty[1];
    assign if0.fifo_rd_data  = mem[0][rp[0]];
    assign if1.fifo_rd_data  = lat_d;
    assign if0.fifo_rd_empty = emp[0];
    assign if1.fifo_rd_empty = emp[1];
    assign if0.en = en[0];
    assign if1.en = en[1];
    assign if0.m_ready = m_ready[0];
    assign if1.m_ready = m_ready[1];
    assign inc = {if1.fifo_rd_inc, if0.fifo_rd_inc};
    assign mv  = {if1.m_valid, if0.m_valid};
    assign ml  = {if1.m_last, if0.m_last};
    assign bz  = {if1.busy, if0.busy};
    assign md[0] = if0.m_data;
    assign md[1] = if1.m_data;
    assign pk[0] = if0.pkt_count;
    assign pk[1] = if1.pkt_count;

    // Behavioural FIFOs: lane 0 shows data combinationally, lane 1 one cycle after the pop.
    always @(posedge clk) begin
        if (rst) begin
            rp[0] <= wp[0];
            rp[1] <= wp[1];
        end else begin
            if (inc[0]) rp[0] <= rp[0] + 6'd1;
            if (inc[1]) begin
                rp[1] <= rp[1] + 6'd1;
                lat_d <= mem[1][rp[1]];
            end
        end
    end

    initial begin : monitor
        logic [8:0] e;
        logic [1:0] stall_prev;
        logic [7:0] prev_d [2];
        logic [1:0] prev_l;
        stall_prev = 2'b00;
        forever begin
            @(negedge clk);
            cyc++;
            for (int l = 0; l < 2; l++) begin
                if (rst) begin
                    stall_prev[l] = 1'b0;
                end else begin
                    if (inc[l]) begin
                        checks++;
                        if (emp[l]) begin
                            errors++;
                            $display("FAIL pop_while_empty lane %0d cycle %0d", l, cyc);
                        end
                        if (first_pop[l] < 0) first_pop[l] = cyc;
                    end
                    if (mv[l] && first_vld[l] < 0) first_vld[l] = cyc;
                    if (stall_prev[l]) begin
                        checks++;
                        if (!mv[l] || md[l] != prev_d[l] || ml[l] != prev_l[l]) begin
                            errors++;
                            $display("FAIL hold_stable lane %0d got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b",
                                     l, mv[l], md[l], ml[l], prev_d[l], prev_l[l]);
                        end
                    end
                    if (mv[l] && m_ready[l]) begin
                        checks++;
                        if (exp_q[l].size() == 0) begin
                            errors++;
                            $display("FAIL extra_xfer lane %0d got d=%02h l=%0b want none", l, md[l], ml[l]);
                        end else begin
                            e = exp_q[l].pop_front();
                            if ({ml[l], md[l]} != e) begin
                                errors++;
                                $display("FAIL xfer lane %0d got d=%02h l=%0b want d=%02h l=%0b",
                                         l, md[l], ml[l], e[7:0], e[8]);
                            end
                        end
                        if (first_x[l] < 0) first_x[l] = cyc;
                        last_x[l] = cyc;
                    end
                    stall_prev[l] = mv[l] && !m_ready[l];
                    prev_d[l] = md[l];
                    prev_l[l] = ml[l];
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic push(input int l, input logic [7:0] d, input logic last, input bit expect_it);
        mem[l][wp[l]] = d;
        wp[l] = wp[l] + 6'd1;
        if (expect_it) exp_q[l].push_back({last, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int l, input int budget, input string name);
        int n;
        n = 0;
        while (exp_q[l].size() != 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (exp_q[l].size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending want 0", name, exp_q[l].size());
        end
    endtask

    initial begin : stim
        int pops;
        int n;
        rst = 1'b1;
        en = 2'b00;
        m_ready = 2'b00;
        force_empty = 2'b00;
        repeat (3) step();
        for (int l = 0; l < 2; l++) begin
            check("rst_m_valid", int'(mv[l]), 0);
            check("rst_m_last", int'(ml[l]), 0);
            check("rst_m_data", int'(md[l]), 0);
            check("rst_rd_inc", int'(inc[l]), 0);
            check("rst_pkt_count", int'(pk[l]), 0);
            check("rst_busy", int'(bz[l]), 0);
        end
        rst = 1'b0;
        step();

        // 1: two back-to-back packets
        for (int i = 0; i < 8; i++) push(0, 8'h10 + 8'(i), (i % 4) == 3, 1'b1);
        m_ready[0] = 1'b1;
        en[0] = 1'b1;
        wait_drain(0, 50, "t1");
        check("t1_pkt_count", int'(pk[0]), 2);
        check("t1_xfer_span", last_x[0] - first_x[0], 7);
        en[0] = 1'b0;
        repeat (3) step();
        check("t1_busy_idle", int'(bz[0]), 0);

        // 2: consumer stall fills the two-deep buffer and throttles popping
        for (int i = 0; i < 8; i++) push(0, 8'h20 + 8'(i), (i % 4) == 3, 1'b1);
        m_ready[0] = 1'b0;
        en[0] = 1'b1;
        step();
        pops = 0;
        repeat (5) begin
            @(negedge clk);
            if (inc[0]) pops++;
        end
        check("t2_stall_pops", pops, 2);
        check("t2_head_data", int'(md[0]), 'h20);
        check("t2_head_valid", int'(mv[0]), 1);
        step();
        m_ready[0] = 1'b1;
        wait_drain(0, 50, "t2");
        check("t2_pkt_count", int'(pk[0]), 4);
        en[0] = 1'b0;
        repeat (3) step();

        // 3: en dropped mid-packet, packet is completed then popping stops
        for (int i = 0; i < 8; i++) push(0, 8'h30 + 8'(i), (i % 4) == 3, i < 4);
        m_ready[0] = 1'b1;
        en[0] = 1'b1;
        pops = 0;
        n = 0;
        while (pops < 2 && n < 20) begin
            @(negedge clk);
            if (inc[0]) pops++;
            n++;
        end
        en[0] = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (inc[0]) pops++;
        end
        check("t3_total_pops", pops, 4);
        check("t3_fifo_nonempty", int'(emp[0]), 0);
        wait_drain(0, 20, "t3");
        check("t3_pkt_count", int'(pk[0]), 5);

        // 4: random empty flag and backpressure; leftover 0x34..0x37 drain first
        for (int i = 4; i < 8; i++) exp_q[0].push_back({(i == 7), 8'h30 + 8'(i)});
        for (int i = 0; i < 8; i++) push(0, 8'h40 + 8'(i), (i % 4) == 3, 1'b1);
        en[0] = 1'b1;
        n = 0;
        while (exp_q[0].size() != 0 && n < 400) begin
            force_empty[0] = 1'($urandom_range(0, 1));
            m_ready[0] = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        force_empty[0] = 1'b0;
        m_ready[0] = 1'b1;
        wait_drain(0, 20, "t4");
        check("t4_pkt_count", int'(pk[0]), 8);
        en[0] = 1'b0;
        repeat (3) step();

        // 5: reset with one word delivered and two buffered, then a clean packet
        for (int i = 0; i < 5; i++) push(0, 8'h50 + 8'(i), (i % 4) == 3, i < 4);
        m_ready[0] = 1'b1;
        en[0] = 1'b1;
        step();
        step();
        step();
        m_ready[0] = 1'b0;
        step();
        check("t5_pre_busy", int'(bz[0]), 1);
        check("t5_pre_valid", int'(mv[0]), 1);
        check("t5_pre_head", int'(md[0]), 'h51);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", int'(mv[0]), 0);
        check("t5_rst_last", int'(ml[0]), 0);
        check("t5_rst_busy", int'(bz[0]), 0);
        check("t5_rst_pkt_count", int'(pk[0]), 0);
        exp_q[0].delete();
        en[0] = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push(0, 8'h60 + 8'(i), i == 3, 1'b1);
        m_ready[0] = 1'b1;
        en[0] = 1'b1;
        wait_drain(0, 30, "t5");
        check("t5_pkt_count", int'(pk[0]), 1);
        en[0] = 1'b0;

        // 6: one-cycle read latency FIFO
        for (int i = 0; i < 8; i++) push(1, 8'h10 + 8'(i), (i % 4) == 3, 1'b1);
        m_ready[1] = 1'b1;
        en[1] = 1'b1;
        wait_drain(1, 50, "t6");
        check("t6_first_latency", first_vld[1] - first_pop[1], 2);
        check("t6_xfer_span", last_x[1] - first_x[1], 7);
        check("t6_pkt_count", int'(pk[1]), 2);
        en[1] = 1'b0;
        repeat (3) step();
        check("t6_busy_idle", int'(bz[1]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
